// File: rtl/ws2812_pkg.sv
// Shared types and defaults for the WS2812 frame scheduler: FSM states,
// pixel width, timing defaults and the per-frame configuration record.
package ws2812_pkg;

  localparam int PIXEL_W              = 24;
  localparam int DEFAULT_LATCH_CYCLES = 5000;
  localparam int DEFAULT_DELAY_UNIT   = 100000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RD,
    PRESENT,
    DRAIN,
    LATCH,
    GAP
  } state_t;

  typedef struct packed {
    logic [15:0] num_leds;
    logic [15:0] depth;
    logic [15:0] delay;
  } cfg_t;

  // A zero depth means "send the whole strip".
  function automatic logic [15:0] depth_eff(input cfg_t c);
    return (c.depth != 16'd0) ? c.depth : c.num_leds;
  endfunction

endpackage

// File: rtl/ws2812_delay_timer.sv
// Inter-frame gap timer: a 32-bit prescaler of DELAY_UNIT clocks feeding a
// 16-bit unit counter; expire is high during the last cycle of the gap.
module ws2812_delay_timer
  import ws2812_pkg::*;
#(
  parameter int DELAY_UNIT = DEFAULT_DELAY_UNIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] load_units,
  output logic        expire
);

  localparam logic [31:0] PRE_LOAD = 32'(DELAY_UNIT - 1);

  logic        running;
  logic [15:0] unit_cnt;
  logic [31:0] pre_cnt;

  // Both counters only count down and stop at zero, so a gap can never wrap.
  assign expire = running && (pre_cnt == 32'd0) && (unit_cnt == 16'd0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      running  <= 1'b0;
      unit_cnt <= 16'd0;
      pre_cnt  <= 32'd0;
    end else if (start) begin
      running  <= (load_units != 16'd0);
      unit_cnt <= load_units - 16'd1;
      pre_cnt  <= PRE_LOAD;
    end else if (running) begin
      if (pre_cnt != 32'd0) begin
        pre_cnt <= pre_cnt - 32'd1;
      end else if (unit_cnt != 16'd0) begin
        unit_cnt <= unit_cnt - 16'd1;
        pre_cnt  <= PRE_LOAD;
      end else begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ws2812_frame_sched.sv
// Frame scheduler: reads pixels from a buffer, hands them one at a time to the
// WS2812 serializer, then holds the latch low-time and optional inter-frame gap.
module ws2812_frame_sched
  import ws2812_pkg::*;
#(
  parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
  parameter int DELAY_UNIT   = DEFAULT_DELAY_UNIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_write,
  input  logic [15:0]        cfg_num_leds,
  input  logic [15:0]        cfg_data_depth,
  input  logic [15:0]        cfg_data_delay,
  output logic               pix_rd_en,
  output logic [15:0]        pix_addr,
  input  logic [PIXEL_W-1:0] pix_rd_data,
  output logic               px_valid,
  output logic [PIXEL_W-1:0] px_data,
  input  logic               px_ready,
  input  logic               ser_idle,
  output logic               latch_active,
  output logic               frame_done,
  output logic               busy
);

  localparam logic [31:0] LATCH_LOAD = 32'(LATCH_CYCLES - 1);

  state_t      state, state_nxt;
  cfg_t        shadow_cfg, active_cfg, cfg_in, cfg_next;
  logic        cfg_pending;
  logic [15:0] active_depth, next_depth;
  logic [31:0] lat_cnt;
  logic        last_word;
  logic        apply_cfg;
  logic        timer_start, timer_expire;

  assign cfg_in = '{num_leds: cfg_num_leds, depth: cfg_data_depth, delay: cfg_data_delay};

  // A write landing on the same edge as a launch or restart wins over the shadow.
  assign cfg_next     = cfg_write ? cfg_in : shadow_cfg;
  assign active_depth = depth_eff(active_cfg);
  assign next_depth   = depth_eff(cfg_next);

  // 17-bit compare so a depth of 0xFFFF ends the frame without pix_addr wrapping.
  assign last_word = ({1'b0, pix_addr} + 17'd1) >= {1'b0, active_depth};

  assign pix_rd_en    = (state == FETCH);
  assign px_valid     = (state == PRESENT);
  assign latch_active = (state == LATCH);
  assign frame_done   = (state == LATCH) && (lat_cnt == 32'd0);
  assign busy         = (state != IDLE);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_nxt   = state;
    apply_cfg   = 1'b0;
    timer_start = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_pending) begin
          apply_cfg = 1'b1;
          if (next_depth != 16'd0) state_nxt = FETCH;
        end
      end
      FETCH:   state_nxt = WAIT_RD;
      WAIT_RD: state_nxt = PRESENT;
      PRESENT: begin
        if (px_ready) state_nxt = last_word ? DRAIN : FETCH;
      end
      DRAIN: begin
        if (ser_idle) state_nxt = LATCH;
      end
      LATCH: begin
        if (lat_cnt == 32'd0) begin
          if (active_cfg.delay != 16'd0) begin
            state_nxt   = GAP;
            timer_start = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        if (timer_expire) begin
          apply_cfg = cfg_pending || cfg_write;
          if ((apply_cfg ? next_depth : active_depth) != 16'd0) state_nxt = FETCH;
          else                                                    state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shadow_cfg  <= '0;
      active_cfg  <= '0;
      cfg_pending <= 1'b0;
      pix_addr    <= 16'd0;
      px_data     <= '0;
      lat_cnt     <= 32'd0;
    end else begin
      state <= state_nxt;

      if (cfg_write) shadow_cfg <= cfg_in;
      if (apply_cfg) begin
        active_cfg  <= cfg_next;
        cfg_pending <= 1'b0;
      end else if (cfg_write) begin
        cfg_pending <= 1'b1;
      end

      if ((state == IDLE || state == GAP) && state_nxt == FETCH) begin
        pix_addr <= 16'd0;
      end else if (state == PRESENT && px_ready) begin
        pix_addr <= pix_addr + 16'd1;
      end

      if (state == WAIT_RD) px_data <= pix_rd_data;

      if (state == DRAIN && ser_idle) begin
        lat_cnt <= LATCH_LOAD;
      end else if (state == LATCH && lat_cnt != 32'd0) begin
        lat_cnt <= lat_cnt - 32'd1;
      end
    end
  end

  ws2812_delay_timer #(
    .DELAY_UNIT(DELAY_UNIT)
  ) u_delay_timer (
    .clk       (clk),
    .reset     (reset),
    .start     (timer_start),
    .load_units(active_cfg.delay),
    .expire    (timer_expire)
  );

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Self-checking bench: a pixel-memory / serializer model drives the scheduler
// and a frame-level reference checks words, latch length, gaps and reset.
module tb_ws2812_frame_sched;

  localparam int LATCH = 5000;
  localparam int UNIT  = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_write = 1'b0;
  logic [15:0] cfg_num_leds = '0, cfg_data_depth = '0, cfg_data_delay = '0;
  logic        pix_rd_en;
  logic [15:0] pix_addr;
  logic [23:0] pix_rd_data = '0;
  logic        px_valid;
  logic [23:0] px_data;
  logic        px_ready = 1'b1;
  logic        ser_idle = 1'b1;
  logic        latch_active, frame_done, busy;

  ws2812_frame_sched #(
    .LATCH_CYCLES(LATCH),
    .DELAY_UNIT  (UNIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_write     (cfg_write),
    .cfg_num_leds  (cfg_num_leds),
    .cfg_data_depth(cfg_data_depth),
    .cfg_data_delay(cfg_data_delay),
    .pix_rd_en     (pix_rd_en),
    .pix_addr      (pix_addr),
    .pix_rd_data   (pix_rd_data),
    .px_valid      (px_valid),
    .px_data       (px_data),
    .px_ready      (px_ready),
    .ser_idle      (ser_idle),
    .latch_active  (latch_active),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state: pixel memory, per-frame word counts and gap lengths.
  logic [23:0] mem [64];
  int          frame_words[$];
  int          word_idx = 0, valid_run = 0, lat_len = 0, gap_cnt = 0, exp_gap = 0;
  int          ser_busy = 0, stall_left = 0, rd_count = 0, busy_count = 0, gaps_seen = 0;
  bit          rd_outstanding = 0, gap_open = 0, rd_prev = 0;
  bit          ready_rand = 0, ser_rand = 0, stall_armed = 0, stall_check = 0;
  logic [15:0] addr_prev = '0;

  // Observe cycle k at its falling edge, then set the inputs the DUT samples
  // at the end of cycle k.
  always @(negedge clk) begin
    pix_rd_data = rd_prev ? mem[addr_prev[5:0]] : 24'($urandom);
    rd_prev     = pix_rd_en && !reset;
    addr_prev   = pix_addr;
    if (reset) begin
      word_idx = 0; valid_run = 0; lat_len = 0; gap_open = 0;
      rd_outstanding = 0; ser_busy = 0; stall_left = 0;
      px_ready = 1'b1;
    end else begin
      if (busy) busy_count++;
      if (pix_rd_en) begin
        rd_count++;
        check("rd_addr", int'(pix_addr), word_idx);
        check("rd_overlap", int'(rd_outstanding), 0);
        rd_outstanding = 1;
        if (gap_open) begin
          check("gap_len", gap_cnt, exp_gap);
          gap_open = 0;
          gaps_seen++;
        end
      end else if (gap_open) begin
        if (!busy) gap_open = 0;
        else       gap_cnt++;
      end

      if (px_valid && stall_armed && word_idx == 1) begin
        stall_left  = 10;
        stall_armed = 0;
      end
      if (stall_left > 0) begin
        px_ready = 1'b0;
        stall_left--;
      end else begin
        px_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end

      if (px_valid) begin
        valid_run++;
        check("px_data", int'(px_data), int'(mem[word_idx % 64]));
        if (px_ready) begin
          if (stall_check && word_idx == 1) begin
            check("stall_hold", valid_run, 11);
            stall_check = 0;
          end
          word_idx++;
          valid_run = 0;
          rd_outstanding = 0;
          ser_busy = ser_rand ? int'($urandom_range(0, 40)) : 0;
        end
      end else if (ser_busy > 0) begin
        ser_busy--;
      end

      if (latch_active) lat_len++;
      if (frame_done) begin
        check("done_in_latch", int'(latch_active), 1);
        check("latch_len", lat_len, LATCH);
        check("done_rd_pending", int'(rd_outstanding), 0);
        frame_words.push_back(word_idx);
        word_idx = 0; lat_len = 0; gap_open = 1; gap_cnt = 0;
      end
    end
    ser_idle = (ser_busy == 0);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic write_cfg(input int n, input int d, input int dl);
    cfg_num_leds   = 16'(n);
    cfg_data_depth = 16'(d);
    cfg_data_delay = 16'(dl);
    cfg_write      = 1'b1;
    step();
    cfg_write      = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int t = 0;
    while (frame_words.size() < target && t < budget) begin
      step();
      t++;
    end
    check({tag, "_frames_reached"}, int'(frame_words.size() >= target), 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int t = 0;
    while (busy && t < budget) begin
      step();
      t++;
    end
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},  int'(pix_rd_en), 0);
    check({tag, "_addr"},   int'(pix_addr), 0);
    check({tag, "_valid"},  int'(px_valid), 0);
    check({tag, "_data"},   int'(px_data), 0);
    check({tag, "_latch"},  int'(latch_active), 0);
    check({tag, "_done"},   int'(frame_done), 0);
    check({tag, "_busy"},   int'(busy), 0);
  endtask

  initial begin
    int fc, rc, bc, gs, t, n, d, exp_words;
    for (int i = 0; i < 64; i++) mem[i] = 24'($urandom);

    reset = 1'b1;
    step(3);
    check_reset_outputs("rst");
    reset = 1'b0;
    step(2);

    // Three LEDs, full strip, one-shot.
    write_cfg(3, 0, 0);
    wait_frames(1, 6000, "s1");
    step(5);
    check("s1_words", frame_words[0], 3);
    check("s1_frames", frame_words.size(), 1);
    check("s1_busy", int'(busy), 0);
    check("s1_addr_end", int'(pix_addr), 3);

    // Serializer stalls word 1 for ten cycles and drains slowly.
    stall_armed = 1; stall_check = 1; ser_rand = 1;
    write_cfg(4, 0, 0);
    wait_frames(2, 7000, "s2");
    wait_idle(100, "s2");
    check("s2_words", frame_words[1], 4);
    check("s2_stall_seen", int'(stall_check), 0);

    // Repeating two-pixel frames with a one-unit gap, then stop via depth 0.
    ser_rand = 0; ready_rand = 1; exp_gap = UNIT;
    gs = gaps_seen;
    write_cfg(9, 2, 1);
    wait_frames(5, 16000, "s3");
    write_cfg(0, 0, 0);
    wait_idle(300, "s3");
    for (int i = 2; i < 5; i++) check("s3_words", frame_words[i], 2);
    check("s3_gaps", gaps_seen - gs, 2);
    step(100);
    check("s3_stopped", frame_words.size(), 5);

    // Reconfigure mid-frame 2 of a three-LED run.
    ready_rand = 0;
    write_cfg(3, 0, 1);
    wait_frames(6, 6000, "s4a");
    t = 0;
    while (word_idx < 1 && t < 200) begin
      step();
      t++;
    end
    check("s4_midframe_reached", int'(word_idx >= 1), 1);
    write_cfg(5, 0, 1);
    wait_frames(8, 12000, "s4b");
    write_cfg(0, 0, 0);
    wait_idle(300, "s4");
    check("s4_frame2_words", frame_words[6], 3);
    check("s4_frame3_words", frame_words[7], 5);

    // Zero-length strip: nothing happens.
    fc = frame_words.size(); rc = rd_count; bc = busy_count;
    write_cfg(0, 0, 0);
    step(50);
    check("s5_no_reads", rd_count - rc, 0);
    check("s5_no_busy", busy_count - bc, 0);
    check("s5_no_done", frame_words.size() - fc, 0);

    // Write landing on the launch edge overrides the pending one.
    fc = frame_words.size();
    write_cfg(1, 0, 0);
    write_cfg(6, 4, 0);
    wait_frames(fc + 1, 6000, "s8");
    step(50);
    check("s8_words", frame_words[fc], 4);
    check("s8_single_frame", frame_words.size() - fc, 1);

    // Reset in the middle of the latch low-time.
    write_cfg(2, 0, 0);
    t = 0;
    while (!latch_active && t < 500) begin
      step();
      t++;
    end
    check("s6_latch_reached", int'(latch_active), 1);
    step(100);
    fc = frame_words.size();
    reset = 1'b1;
    step();
    check_reset_outputs("s6");
    reset = 1'b0;
    step(LATCH + 100);
    check("s6_no_done", frame_words.size() - fc, 0);
    check("s6_busy", int'(busy), 0);

    // Random strips with random handshake and drain timing.
    ready_rand = 1; ser_rand = 1;
    for (int it = 0; it < 2; it++) begin
      n = int'($urandom_range(1, 10));
      d = int'($urandom_range(0, 10));
      exp_words = (d != 0) ? d : n;
      fc = frame_words.size();
      write_cfg(n, d, 0);
      wait_frames(fc + 1, 8000, "rnd");
      wait_idle(100, "rnd");
      check("rnd_words", frame_words[fc], exp_words);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ws2812_frame_sched.md
WS2812_FRAME_SCHED -- requirements
Module: ws2812_frame_sched

Interface
REQ-001 Parameter LATCH_CYCLES, default 5000, latch low-time after last pixel, in clk cycles (50 us at 100 MHz).
REQ-002 Parameter DELAY_UNIT, default 100000, clk cycles per data_delay count (1 ms at 100 MHz).
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cfg_write  in  1  one-cycle strobe; capture cfg_num_leds, cfg_data_depth, cfg_data_delay.
REQ-006 cfg_num_leds  in  16  physical LED count.
REQ-007 cfg_data_depth  in  16  pixels to send per frame; 0 means use cfg_num_leds.
REQ-008 cfg_data_delay  in  16  inter-frame gap in DELAY_UNIT steps; 0 means one-shot.
REQ-009 pix_rd_en  out  1  pixel buffer read strobe.
REQ-010 pix_addr  out  16  pixel buffer address.
REQ-011 pix_rd_data  in  24  GRB pixel, valid exactly one cycle after pix_rd_en.
REQ-012 px_valid  out  1  pixel word offered to serializer.
REQ-013 px_data  out  24  pixel word to serializer.
REQ-014 px_ready  in  1  serializer accepts word when px_valid && px_ready.
REQ-015 ser_idle  in  1  serializer has finished shifting all accepted bits.
REQ-016 latch_active  out  1  high during latch low-time.
REQ-017 frame_done  out  1  one-cycle pulse at end of latch.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 States: IDLE, FETCH, WAIT_RD, PRESENT, DRAIN, LATCH, GAP.
REQ-020 cfg_write in any state loads the shadow registers and sets cfg_pending.
REQ-021 Shadow values are copied to the active registers only in IDLE or at GAP expiry; a running frame never uses a partially applied config.
REQ-022 Effective depth: depth_eff = cfg_data_depth when nonzero, otherwise cfg_num_leds; the 16-bit compare is unsigned.
REQ-023 IDLE -> FETCH when cfg_pending and depth_eff != 0. Clear cfg_pending and set pix_addr = 0.
REQ-024 If depth_eff == 0, stay in IDLE and clear cfg_pending; no pulses are produced.
REQ-025 FETCH: assert pix_rd_en for exactly one cycle, then go to WAIT_RD.
REQ-026 WAIT_RD: register pix_rd_data into px_data, then go to PRESENT.
REQ-027 PRESENT: hold px_valid high with px_data stable until px_ready is seen. On acceptance, increment pix_addr.
REQ-028 In PRESENT, after acceptance go to FETCH if pix_addr+1 < depth_eff, otherwise go to DRAIN.
REQ-029 px_valid deasserts in the cycle after acceptance. Back-to-back words are not required; max throughput is one word per 3 cycles.
REQ-030 DRAIN: wait for ser_idle = 1, then go to LATCH and load the latch counter with LATCH_CYCLES-1.
REQ-031 LATCH: latch_active = 1 while the counter decrements. When the counter reaches 0, pulse frame_done.
REQ-032 At latch expiry, go to GAP if data_delay != 0; otherwise go to IDLE.
REQ-033 GAP: count data_delay*DELAY_UNIT cycles using a 16-bit unit counter and a 32-bit prescaler; no wrap is permitted.
REQ-034 At GAP expiry, apply any pending config and restart at FETCH with pix_addr = 0.
REQ-035 If the applied config gives depth_eff == 0 at GAP expiry, go to IDLE.
REQ-036 cfg_write in the same cycle as GAP expiry is applied to that restart.
REQ-037 cfg_write in the same cycle as IDLE launch: the new values are used and cfg_pending remains clear.
REQ-038 depth_eff = 0xFFFF is legal; pix_addr never wraps within a frame.

Reset
REQ-039 On reset, outputs take these values: pix_rd_en=0, pix_addr=0, px_valid=0, px_data=0, latch_active=0, frame_done=0, busy=0.
REQ-040 On reset, the state returns to IDLE; counters, shadow and active registers, and cfg_pending are cleared.
REQ-041 Reset mid-frame abandons the frame in the following cycle; no frame_done pulse is produced.

Structure
REQ-042 A shared package ws2812_pkg holds the state enum, pixel width (24), the default LATCH_CYCLES and DELAY_UNIT, and the config record (num_leds, depth, delay).
REQ-043 The GAP prescaler plus unit counter is one sub-module, ws2812_delay_timer (load, start, expire pulse).

Verification
REQ-044 Scenario: num_leds=3, depth=0, delay=0, cfg_write, px_ready always 1. Expect 3 words from addr 0,1,2; then latch_active for 5000 cycles; one frame_done pulse; then IDLE.
REQ-045 Scenario: px_ready held low for 10 cycles on word 1. Expect px_valid high and px_data stable throughout; addr 1 is not re-read; no words are lost.
REQ-046 Scenario: depth=2, delay=1, DELAY_UNIT=20. Expect frames repeating; each frame_done is followed by a 20-cycle gap, then pix_addr=0 again.
REQ-047 Scenario: cfg_write (num_leds=5) at mid-frame 2 of a 3-LED run. Expect frame 2 to send 3 words and frame 3 to send 5 words.
REQ-048 Scenario: num_leds=0, depth=0, cfg_write. Expect no pix_rd_en, busy stays 0, and no frame_done.
REQ-049 Scenario: reset asserted during LATCH. Expect next-cycle latch_active=0, busy=0, and no frame_done pulse.
